// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 Hz raster constants, total-length
// derivation helpers and the sync polarity encoding shared by the VGA
// timing generator.
package vga_timing_pkg;

    // Default horizontal geometry (pixels)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Default vertical geometry (lines)
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Coordinate width; every axis total must fit in it
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1 << CNT_W;

    // Level driven on hsync/vsync while the pulse is active
    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    function automatic int unsigned h_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: modulo-MODULUS counter with count enable and a
// combinational wrap flag (asserted while enabled on the last count).
module vga_axis_counter #(
    parameter int unsigned MODULUS = 800,
    parameter int unsigned WIDTH   = 10
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = en && (count == LAST);

    // Advance on enable, returning to zero after the last count
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 Hz raster timing generator on the 25 MHz pixel
// clock. Produces registered coordinates, syncs, blank and line/frame
// strobes, all one cycle behind the internal (hc, vc) counters.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit
// frame_cnt output counting frame_tick pulses.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter sync_pol_e   SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             clk25,
    input  logic             rst_n,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             line_tick,
    output logic             frame_tick
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_check
        $error("vga_timing: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d",
               H_TOTAL, V_TOTAL, MAX_TOTAL);
    end

    localparam logic [CNT_W-1:0] H_BLANK_START = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_BLANK_START = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST      = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST       = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST      = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST       = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON       = logic'(SYNC_POL);
    localparam logic             SYNC_OFF      = ~SYNC_ON;

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             h_wrap;
    logic             v_wrap_unused;

    logic             h_in_sync;
    logic             v_in_sync;
    logic             in_blank;
    logic             line_start;
    logic             frame_start;

    vga_axis_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (CNT_W)
    ) u_hcnt (
        .clk25 (clk25),
        .rst_n (rst_n),
        .en    (1'b1),
        .count (hc),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (CNT_W)
    ) u_vcnt (
        .clk25 (clk25),
        .rst_n (rst_n),
        .en    (h_wrap),
        .count (vc),
        .wrap  (v_wrap_unused)
    );

    // Decode the current counter position into raster conditions
    always_comb begin
        h_in_sync   = (hc >= HS_FIRST) && (hc <= HS_LAST);
        v_in_sync   = (vc >= VS_FIRST) && (vc <= VS_LAST);
        in_blank    = (hc >= H_BLANK_START) || (vc >= V_BLANK_START);
        line_start  = (hc == '0);
        frame_start = (hc == '0) && (vc == V_BLANK_START);
    end

    // Register every per-pixel output on the same edge so they stay coherent
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            hsync      <= SYNC_OFF;
            vsync      <= SYNC_OFF;
            blank      <= 1'b1;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            x          <= hc;
            y          <= vc;
            hsync      <= h_in_sync ? SYNC_ON : SYNC_OFF;
            vsync      <= v_in_sync ? SYNC_ON : SYNC_OFF;
            blank      <= in_blank;
            line_tick  <= line_start;
            frame_tick <= frame_start;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Count frames; bumps on the same edge that raises frame_tick
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator for the 640x480@60 Hz VGA output path. It runs on the 25 MHz pixel clock and produces the pixel coordinates, sync pulses, blanking flag and per-line/per-frame strobes. The Pong top level consumes these outputs: x/y drive the sprite compare, hsync/vsync/blank drive the DAC pins, and frame_tick paces game-state updates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- clk25  in  1  pixel clock, 25 MHz; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- x  out  10  horizontal count 0..H_TOTAL-1, raw value, also valid during blanking
- y  out  10  vertical count 0..V_TOTAL-1, raw value
- hsync  out  1  horizontal sync at SYNC_POL level during the sync interval
- vsync  out  1  vertical sync at SYNC_POL level during the sync interval
- blank  out  1  1 = outside the active area (top level drives VGA_BLANK = ~blank)
- line_tick  out  1  one-cycle pulse when x = 0
- frame_tick  out  1  one-cycle pulse when x = 0 and y = V_ACTIVE (start of vblank)
- frame_cnt  out  16  frames completed; present only with VGA_TIMING_FRAME_CNT_EN

## Operation
- H_TOTAL = sum of H_* parameters (800); V_TOTAL = sum of V_* parameters (525). Both must be ≤ 1024. An elaboration-time error fires otherwise.
- Horizontal counter hc increments every cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counter vc increments only when hc wraps. When hc and vc both wrap, vc returns to 0.
- Outputs are decoded from (hc, vc) and registered:
  - blank = (hc ≥ H_ACTIVE) | (vc ≥ V_ACTIVE)
  - hsync is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751], on every line including vblank lines
  - vsync is active for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491], across the whole line
- All registered outputs for one pixel change on the same edge. x, y, syncs, blank and ticks are mutually coherent.
- frame_cnt increments by 1 on each frame_tick. It wraps from 0xFFFF to 0.

## Timing
- Reset, asynchronous assert and while held:
  - hc = vc = 0
  - x = y = 0
  - hsync = vsync = ~SYNC_POL
  - blank = 1
  - line_tick = frame_tick = 0
  - frame_cnt = 0
- First rising edge after deassert: outputs show pixel (0,0) with blank = 0 and line_tick = 1. Counters advance to (1,0).
- Latency: exactly one clk25 cycle from counter value to the outputs.
- Line period is 800 cycles; frame period is 420000 cycles. frame_tick recurs every 420000 cycles.
- Reset asserted mid-frame: all state returns to reset values immediately. No partial sync pulse is completed.
- Line wrap and frame wrap coincide at (799, 524) → (0, 0). line_tick fires at (0, 0); frame_tick does not.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: the frame_cnt port and its 16-bit register exist.
- Undefined: the port and register are absent. All other behaviour is identical.

## Structure
- vga_timing_pkg holds:
  - the default 640x480 constants
  - H_TOTAL/V_TOTAL derivation functions
  - the SYNC_POL encoding
- Sub-module vga_axis_counter: a parameterised modulo counter with enable and wrap output. It is instantiated twice:
  - horizontal: enable = 1
  - vertical: enable = horizontal wrap

## Test plan
- Reset held for 10 cycles, then released → during reset x=0, y=0, blank=1, hsync=vsync=1. The first post-release edge gives x=0, y=0, blank=0, line_tick=1.
- Run one line → blank rises at x=640; hsync falls at x=656 and rises at x=752; x wraps 799→0 while y goes 0→1.
- Run to y=480 → frame_tick=1 for exactly one cycle at x=0, y=480. vsync is low only for y=490..491. blank=1 for all of y≥480.
- Run 2 full frames → frame_tick spacing is exactly 420000 cycles, and (799,524) is followed by (0,0).
- Assert rst_n at x=700, y=491 (mid-hsync, mid-vsync) → syncs go inactive and x=y=0 immediately, without waiting for a clock edge. The timing restarts cleanly.
- With VGA_TIMING_FRAME_CNT_EN, preload frame_cnt to 0xFFFE by force and run 2 frames → values 0xFFFF, then 0x0000.
